// File: rtl/udp_cmd_ctrl.sv
// UDP command decoder: parses opcode/divisor packets, drives the image-transfer
// FSM and frame decimation, and queues an acknowledge (or NAK) per packet.
module udp_cmd_ctrl #(
  parameter logic [7:0] CMD_START = 8'h31,
  parameter logic [7:0] CMD_STOP  = 8'h30,
  parameter logic [7:0] CMD_SNAP  = 8'h53,
  parameter logic [7:0] CMD_RATE  = 8'h52,
  parameter logic [7:0] ERR_CODE  = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        udp_rec_en,
  input  logic [7:0]  udp_rec_data,
  input  logic        udp_rec_pkt_done,
  input  logic [15:0] udp_rec_byte_num,
  input  logic        frame_done,
  input  logic        ack_ack,
  output logic        transfer_flag,
  output logic        frame_req,
  output logic        ack_req,
  output logic [7:0]  ack_code,
  output logic        cmd_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_SNAP} state_t;

  state_t      state_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  op_q, div_hi_q, div_lo_q;
  logic [15:0] div_q, skip_cnt_q;
  logic        transfer_flag_q, frame_req_q, ack_req_q, cmd_err_q;
  logic [7:0]  ack_code_q;

  // Fold in a byte that lands together with pkt_done so it is validated too.
  logic [7:0]  cur_op, cur_hi, cur_lo;
  logic [15:0] cur_div;
  logic        is_start, is_stop, is_snap, is_rate, pkt_valid;

  assign cur_op  = (udp_rec_en && byte_cnt_q == 2'd0) ? udp_rec_data : op_q;
  assign cur_hi  = (udp_rec_en && byte_cnt_q == 2'd1) ? udp_rec_data : div_hi_q;
  assign cur_lo  = (udp_rec_en && byte_cnt_q == 2'd2) ? udp_rec_data : div_lo_q;
  assign cur_div = {cur_hi, cur_lo};

  assign is_start  = (cur_op == CMD_START) && (udp_rec_byte_num == 16'd1);
  assign is_stop   = (cur_op == CMD_STOP)  && (udp_rec_byte_num == 16'd1);
  assign is_snap   = (cur_op == CMD_SNAP)  && (udp_rec_byte_num == 16'd1);
  assign is_rate   = (cur_op == CMD_RATE)  && (udp_rec_byte_num == 16'd3) && (cur_div != 16'd0);
  assign pkt_valid = is_start || is_stop || is_snap || is_rate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      byte_cnt_q      <= 2'd0;
      op_q            <= 8'd0;
      div_hi_q        <= 8'd0;
      div_lo_q        <= 8'd0;
      div_q           <= 16'd1;
      skip_cnt_q      <= 16'd0;
      transfer_flag_q <= 1'b0;
      frame_req_q     <= 1'b0;
      ack_req_q       <= 1'b0;
      ack_code_q      <= 8'd0;
      cmd_err_q       <= 1'b0;
    end else begin
      frame_req_q <= 1'b0;
      cmd_err_q   <= 1'b0;

      // Packet byte capture; buffers are wiped at packet end so stale bytes
      // from a longer earlier packet can never validate a short one.
      if (udp_rec_pkt_done) begin
        byte_cnt_q <= 2'd0;
        op_q       <= 8'd0;
        div_hi_q   <= 8'd0;
        div_lo_q   <= 8'd0;
      end else if (udp_rec_en) begin
        case (byte_cnt_q)
          2'd0:    op_q     <= udp_rec_data;
          2'd1:    div_hi_q <= udp_rec_data;
          2'd2:    div_lo_q <= udp_rec_data;
          default: ;
        endcase
        if (byte_cnt_q != 2'd3)
          byte_cnt_q <= byte_cnt_q + 2'd1;
      end

      if (udp_rec_pkt_done) begin
        ack_req_q  <= 1'b1;
        ack_code_q <= pkt_valid ? cur_op : ERR_CODE;
        cmd_err_q  <= !pkt_valid;
      end else if (ack_ack) begin
        ack_req_q  <= 1'b0;
      end

      // A valid command consumes any coincident frame_done.
      if (udp_rec_pkt_done && pkt_valid) begin
        if (is_start) begin
          state_q         <= ST_STREAM;
          transfer_flag_q <= 1'b1;
          skip_cnt_q      <= 16'd0;
        end else if (is_stop) begin
          state_q         <= ST_IDLE;
          transfer_flag_q <= 1'b0;
        end else if (is_snap) begin
          if (state_q == ST_IDLE) begin
            state_q         <= ST_SNAP;
            transfer_flag_q <= 1'b1;
          end
        end else begin
          div_q      <= cur_div;
          skip_cnt_q <= 16'd0;
        end
      end else if (frame_done) begin
        case (state_q)
          ST_STREAM: begin
            if (skip_cnt_q == div_q - 16'd1) begin
              frame_req_q <= 1'b1;
              skip_cnt_q  <= 16'd0;
            end else begin
              skip_cnt_q  <= skip_cnt_q + 16'd1;
            end
          end
          ST_SNAP: begin
            frame_req_q     <= 1'b1;
            state_q         <= ST_IDLE;
            transfer_flag_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign transfer_flag = transfer_flag_q;
  assign frame_req     = frame_req_q;
  assign ack_req       = ack_req_q;
  assign ack_code      = ack_code_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_udp_cmd_ctrl.sv
// Table-driven bench for udp_cmd_ctrl with an acknowledge scoreboard and
// hand-written sequences for ack overlap and mid-packet reset.
module tb_udp_cmd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        udp_rec_en;
  logic [7:0]  udp_rec_data;
  logic        udp_rec_pkt_done;
  logic [15:0] udp_rec_byte_num;
  logic        frame_done;
  logic        ack_ack;
  logic        transfer_flag;
  logic        frame_req;
  logic        ack_req;
  logic [7:0]  ack_code;
  logic        cmd_err;

  udp_cmd_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .udp_rec_en       (udp_rec_en),
    .udp_rec_data     (udp_rec_data),
    .udp_rec_pkt_done (udp_rec_pkt_done),
    .udp_rec_byte_num (udp_rec_byte_num),
    .frame_done       (frame_done),
    .ack_ack          (ack_ack),
    .transfer_flag    (transfer_flag),
    .frame_req        (frame_req),
    .ack_req          (ack_req),
    .ack_code         (ack_code),
    .cmd_err          (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_pkt;
    int          nb;
    logic [7:0]  b0, b1, b2;
    logic [15:0] len;
    logic        exp_err;
    logic [7:0]  exp_code;
    logic        exp_tf;
    logic        exp_fr;
  } vec_t;

  typedef struct {
    logic [7:0] code;
    logic       err;
  } ack_t;

  vec_t vecs[$];
  ack_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk_pkt(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [15:0] len,
                                  input logic err, input logic [7:0] code, input logic tf);
    vec_t v;
    v.is_pkt = 1'b1; v.nb = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.len = len;
    v.exp_err = err; v.exp_code = code; v.exp_tf = tf; v.exp_fr = 1'b0;
    return v;
  endfunction

  function automatic vec_t mk_frm(input logic fr, input logic tf);
    vec_t v;
    v.is_pkt = 1'b0; v.nb = 0; v.b0 = 8'd0; v.b1 = 8'd0; v.b2 = 8'd0; v.len = 16'd0;
    v.exp_err = 1'b0; v.exp_code = 8'd0; v.exp_tf = tf; v.exp_fr = fr;
    return v;
  endfunction

  // Bytes are streamed one per cycle; pkt_done (and optional frame_done/ack_ack)
  // rides on the last byte. Outputs are sampled 1 time unit after the edge
  // that registers pkt_done.
  task automatic send_pkt(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [15:0] len,
                          input logic fd, input logic ak,
                          input logic [7:0] exp_code, input logic exp_err);
    logic [7:0] bytes [3];
    ack_t a;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    a.code = exp_code; a.err = exp_err;
    sb.push_back(a);
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      udp_rec_en   = 1'b1;
      udp_rec_data = bytes[i];
      if (i == nb - 1) begin
        udp_rec_pkt_done = 1'b1;
        udp_rec_byte_num = len;
        frame_done       = fd;
        ack_ack          = ak;
      end
    end
    @(posedge clk); #1;
    udp_rec_en = 1'b0; udp_rec_pkt_done = 1'b0; udp_rec_byte_num = 16'd0;
    frame_done = 1'b0; ack_ack = 1'b0;
    $display("pkt nb=%0d %h %h %h len=%0d -> ack_req=%b code=%h err=%b tf=%b fr=%b",
             nb, b0, b1, b2, len, ack_req, ack_code, cmd_err, transfer_flag, frame_req);
  endtask

  task automatic check_ack(input string nm);
    ack_t a;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty, got code %h want an entry", nm, ack_code);
    end else begin
      a = sb.pop_front();
      chk({nm, ".ack_req"}, 16'(ack_req), 16'd1);
      chk({nm, ".ack_code"}, 16'(ack_code), 16'(a.code));
      chk({nm, ".cmd_err"}, 16'(cmd_err), 16'(a.err));
    end
  endtask

  task automatic do_ack(input string nm);
    @(posedge clk); #1;
    ack_ack = 1'b1;
    @(posedge clk); #1;
    ack_ack = 1'b0;
    chk({nm, ".ack_clr"}, 16'(ack_req), 16'd0);
    chk({nm, ".err_pulse"}, 16'(cmd_err), 16'd0);
  endtask

  task automatic send_frame();
    @(posedge clk); #1;
    frame_done = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
    $display("frame -> fr=%b tf=%b", frame_req, transfer_flag);
  endtask

  initial begin
    rst_n = 1'b0; udp_rec_en = 1'b0; udp_rec_data = 8'd0; udp_rec_pkt_done = 1'b0;
    udp_rec_byte_num = 16'd0; frame_done = 1'b0; ack_ack = 1'b0;

    // START, three frames at div=1
    vecs.push_back(mk_pkt(1, 8'h31, 8'h00, 8'h00, 16'd1, 1'b0, 8'h31, 1'b1));
    repeat (3) vecs.push_back(mk_frm(1'b1, 1'b1));
    // RATE 3 in STREAM: fires on 3rd and 6th frame
    vecs.push_back(mk_pkt(3, 8'h52, 8'h00, 8'h03, 16'd3, 1'b0, 8'h52, 1'b1));
    vecs.push_back(mk_frm(1'b0, 1'b1)); vecs.push_back(mk_frm(1'b0, 1'b1));
    vecs.push_back(mk_frm(1'b1, 1'b1)); vecs.push_back(mk_frm(1'b0, 1'b1));
    vecs.push_back(mk_frm(1'b0, 1'b1)); vecs.push_back(mk_frm(1'b1, 1'b1));
    vecs.push_back(mk_frm(1'b0, 1'b1));
    // STOP, frame ignored in IDLE
    vecs.push_back(mk_pkt(1, 8'h30, 8'h00, 8'h00, 16'd1, 1'b0, 8'h30, 1'b0));
    vecs.push_back(mk_frm(1'b0, 1'b0));
    // SNAP: one frame then back to IDLE
    vecs.push_back(mk_pkt(1, 8'h53, 8'h00, 8'h00, 16'd1, 1'b0, 8'h53, 1'b1));
    vecs.push_back(mk_frm(1'b1, 1'b0));
    vecs.push_back(mk_frm(1'b0, 1'b0));
    // Invalid: zero divisor, START with wrong length
    vecs.push_back(mk_pkt(3, 8'h52, 8'h00, 8'h00, 16'd3, 1'b1, 8'hEE, 1'b0));
    vecs.push_back(mk_pkt(2, 8'h31, 8'h00, 8'h00, 16'd2, 1'b1, 8'hEE, 1'b0));
    // div still 3 after the invalid RATE
    vecs.push_back(mk_pkt(1, 8'h31, 8'h00, 8'h00, 16'd1, 1'b0, 8'h31, 1'b1));
    vecs.push_back(mk_frm(1'b0, 1'b1)); vecs.push_back(mk_frm(1'b0, 1'b1));
    vecs.push_back(mk_frm(1'b1, 1'b1));
    // Invalid packet in STREAM leaves skip_cnt alone
    vecs.push_back(mk_frm(1'b0, 1'b1));
    vecs.push_back(mk_pkt(3, 8'h52, 8'h00, 8'h00, 16'd3, 1'b1, 8'hEE, 1'b1));
    vecs.push_back(mk_frm(1'b0, 1'b1)); vecs.push_back(mk_frm(1'b1, 1'b1));
    // SNAP in STREAM acknowledged but ignored
    vecs.push_back(mk_pkt(1, 8'h53, 8'h00, 8'h00, 16'd1, 1'b0, 8'h53, 1'b1));
    vecs.push_back(mk_frm(1'b0, 1'b1)); vecs.push_back(mk_frm(1'b0, 1'b1));
    vecs.push_back(mk_frm(1'b1, 1'b1));
    // RATE 1, then a divisor with only the MSB set, unknown opcode, STOP
    vecs.push_back(mk_pkt(3, 8'h52, 8'h00, 8'h01, 16'd3, 1'b0, 8'h52, 1'b1));
    vecs.push_back(mk_frm(1'b1, 1'b1)); vecs.push_back(mk_frm(1'b1, 1'b1));
    vecs.push_back(mk_pkt(3, 8'h52, 8'h01, 8'h00, 16'd3, 1'b0, 8'h52, 1'b1));
    vecs.push_back(mk_pkt(1, 8'h41, 8'h00, 8'h00, 16'd1, 1'b1, 8'hEE, 1'b1));
    vecs.push_back(mk_pkt(1, 8'h30, 8'h00, 8'h00, 16'd1, 1'b0, 8'h30, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst.tf", 16'(transfer_flag), 16'd0);
    chk("rst.fr", 16'(frame_req), 16'd0);
    chk("rst.ack_req", 16'(ack_req), 16'd0);
    chk("rst.ack_code", 16'(ack_code), 16'd0);
    chk("rst.cmd_err", 16'(cmd_err), 16'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].is_pkt) begin
        send_pkt(vecs[i].nb, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].len, 1'b0, 1'b0,
                 vecs[i].exp_code, vecs[i].exp_err);
        check_ack($sformatf("v%0d", i));
        chk($sformatf("v%0d.tf", i), 16'(transfer_flag), 16'(vecs[i].exp_tf));
        do_ack($sformatf("v%0d", i));
      end else begin
        send_frame();
        chk($sformatf("v%0d.fr", i), 16'(frame_req), 16'(vecs[i].exp_fr));
        chk($sformatf("v%0d.tf", i), 16'(transfer_flag), 16'(vecs[i].exp_tf));
      end
    end

    // Two unacknowledged packets; ack_ack coinciding with pkt_done is overridden.
    send_pkt(1, 8'h31, 8'h00, 8'h00, 16'd1, 1'b0, 1'b0, 8'h31, 1'b0);
    check_ack("ovl1");
    send_pkt(1, 8'h30, 8'h00, 8'h00, 16'd1, 1'b0, 1'b1, 8'h30, 1'b0);
    check_ack("ovl2");
    @(posedge clk); #1;
    chk("ovl.hold", 16'(ack_req), 16'd1);
    do_ack("ovl");

    // STOP racing a firing frame_done, then reset mid-packet.
    send_pkt(1, 8'h31, 8'h00, 8'h00, 16'd1, 1'b0, 1'b0, 8'h31, 1'b0);
    check_ack("race.start");
    send_pkt(3, 8'h52, 8'h00, 8'h03, 16'd3, 1'b0, 1'b0, 8'h52, 1'b0);
    check_ack("race.rate");
    send_frame();
    chk("race.f1", 16'(frame_req), 16'd0);
    send_frame();
    chk("race.f2", 16'(frame_req), 16'd0);
    send_pkt(1, 8'h30, 8'h00, 8'h00, 16'd1, 1'b1, 1'b0, 8'h30, 1'b0);
    check_ack("race.stop");
    chk("race.fr", 16'(frame_req), 16'd0);
    chk("race.tf", 16'(transfer_flag), 16'd0);
    @(posedge clk); #1;
    chk("race.fr_late", 16'(frame_req), 16'd0);

    @(posedge clk); #1;
    udp_rec_en = 1'b1; udp_rec_data = 8'h52;
    @(posedge clk); #1;
    udp_rec_data = 8'h00;
    @(posedge clk); #1;
    udp_rec_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst.ack_req", 16'(ack_req), 16'd0);
    chk("mrst.ack_code", 16'(ack_code), 16'd0);
    chk("mrst.tf", 16'(transfer_flag), 16'd0);
    chk("mrst.fr", 16'(frame_req), 16'd0);
    chk("mrst.err", 16'(cmd_err), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_pkt(1, 8'h31, 8'h00, 8'h00, 16'd1, 1'b0, 1'b0, 8'h31, 1'b0);
    check_ack("post");
    chk("post.tf", 16'(transfer_flag), 16'd1);
    send_frame();
    chk("post.fr_div1", 16'(frame_req), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
